regfile_sb: RTL and testbench

//  Parametrised integer register file with a per-register scoreboard for the 5-stage pipeline.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_sb_read_port.sv | 30 +++
 rtl/regfile_sb.sv | 72 +++++++
 tb/tb_regfile_sb.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, address-width helper and data/address types for regfile_sb
package regfile_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_NREGS = 32;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef logic [addr_w(DEF_NREGS)-1:0] reg_addr_t;
  typedef logic [DEF_XLEN-1:0] xlen_t;
endpackage

// File: rtl/regfile_sb_read_port.sv
// rf_read_port: one combinational read port with highest-port-wins write bypass and busy masking
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW = addr_w(DEF_NREGS),
  parameter int NWP = 1
) (
  input  logic [AW-1:0]             addr,
  input  logic [XLEN-1:0]           reg_val,
  input  logic                      reg_busy,
  input  logic [NWP-1:0]            we,
  input  logic [NWP-1:0][AW-1:0]    wr_addr,
  input  logic [NWP-1:0][XLEN-1:0]  wr_data,
  output logic [XLEN-1:0]           data,
  output logic                      busy
);
  logic hit;
  always_comb begin
    data = (addr == '0) ? '0 : reg_val;
    hit = 1'b0;
    for (int p = 0; p < NWP; p++) begin
      if (we[p] && wr_addr[p] == addr && addr != '0) begin
        data = wr_data[p];
        hit = 1'b1;
      end
    end
    busy = reg_busy && !hit;
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with write bypass and per-register busy scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRP = 2,
  parameter int NWP = 1,
  localparam int AW = addr_w(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NRP-1:0][AW-1:0]    rs_addr,
  output logic [NRP-1:0][XLEN-1:0]  rs_data,
  output logic [NRP-1:0]            rs_busy,
  input  logic [NWP-1:0]            we,
  input  logic [NWP-1:0][AW-1:0]    wr_addr,
  input  logic [NWP-1:0][XLEN-1:0]  wr_data,
  input  logic                      alloc_valid,
  input  logic [AW-1:0]             alloc_rd,
  output logic                      alloc_stall,
  input  logic                      flush,
  output logic [NREGS-1:0]          busy_vec
);
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0] busy, busy_nxt, wb_clr, alloc_set;
  logic [NWP-1:0] we_g;
  logic alloc_wr_hit, alloc_ok;
  // Write enables are gated by reset so bypass data cannot leak out while reset is held
  assign we_g = rst_n ? we : '0;
  always_comb begin
    wb_clr = '0;
    alloc_wr_hit = 1'b0;
    for (int p = 0; p < NWP; p++) begin
      if (we_g[p]) wb_clr[wr_addr[p]] = 1'b1;
      if (we_g[p] && wr_addr[p] == alloc_rd) alloc_wr_hit = 1'b1;
    end
  end
  assign alloc_stall = alloc_valid && alloc_rd != '0 && busy[alloc_rd] && !alloc_wr_hit;
  assign alloc_ok = alloc_valid && !alloc_stall && !flush && alloc_rd != '0;
  // Priority: flush clears everything, then an accepted alloc overrides a same-reg writeback clear
  always_comb begin
    alloc_set = '0;
    alloc_set[alloc_rd] = alloc_ok;
    busy_nxt = flush ? '0 : ((busy & ~wb_clr) | alloc_set) & {{(NREGS-1){1'b1}}, 1'b0};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      for (int p = 0; p < NWP; p++)
        if (we_g[p] && wr_addr[p] != '0) regs[wr_addr[p]] <= wr_data[p];
    end
  end
  assign busy_vec = busy;
  for (genvar i = 0; i < NRP; i++) begin : g_rp
    rf_read_port #(.XLEN(XLEN), .AW(AW), .NWP(NWP)) u_rp (
      .addr(rs_addr[i]),
      .reg_val(regs[rs_addr[i]]),
      .reg_busy(busy[rs_addr[i]]),
      .we(we_g),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .data(rs_data[i]),
      .busy(rs_busy[i])
    );
  end
  a_zero: assert property (@(posedge clk) disable iff (!rst_n) regs[0] == '0 && !busy[0]);
  a_stall: assert property (@(posedge clk) disable iff (!rst_n) alloc_stall |-> !alloc_ok);
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vectors against hand-computed results for regfile_sb (NRP=2, NWP=2)
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0][4:0] rs_addr;
  logic [1:0][31:0] rs_data;
  logic [1:0] rs_busy;
  logic [1:0] we;
  logic [1:0][4:0] wr_addr;
  logic [1:0][31:0] wr_data;
  logic alloc_valid;
  logic [4:0] alloc_rd;
  logic alloc_stall;
  logic flush;
  logic [31:0] busy_vec;
  int n_vec = 0;
  int n_err = 0;

  regfile_sb #(.XLEN(32), .NREGS(32), .NRP(2), .NWP(2)) dut (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_valid(alloc_valid),
    .alloc_rd(alloc_rd), .alloc_stall(alloc_stall), .flush(flush), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we = '0;
    wr_addr = '0;
    wr_data = '0;
    alloc_valid = 1'b0;
    alloc_rd = '0;
    flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rs_addr = '0;
    idle();
    #2;
    chk("rst_busy_vec", busy_vec, 32'h0);
    chk("rst_stall", {31'b0, alloc_stall}, 32'h0);
    #10 rst_n = 1'b1;
    // 1: reset mid-run
    step();
    we[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF;
    alloc_valid = 1'b1; alloc_rd = 5'd5;
    step();
    idle();
    rs_addr[0] = 5'd5;
    #1;
    chk("t1_x5_written", rs_data[0], 32'hDEAD_BEEF);
    chk("t1_busy5", busy_vec, 32'h0000_0020);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_x5_in_rst", rs_data[0], 32'h0);
    chk("t1_busy_in_rst", busy_vec, 32'h0);
    #8 rst_n = 1'b1;
    step();
    chk("t1_x5_after_rst", rs_data[0], 32'h0);
    chk("t1_busy_after_rst", busy_vec, 32'h0);
    // 2: register 0
    we[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFF_FFFF;
    alloc_valid = 1'b1; alloc_rd = 5'd0;
    rs_addr[0] = 5'd0;
    #1;
    chk("t2_x0_data", rs_data[0], 32'h0);
    chk("t2_x0_busy", {31'b0, rs_busy[0]}, 32'h0);
    chk("t2_x0_stall", {31'b0, alloc_stall}, 32'h0);
    step();
    idle();
    chk("t2_x0_after", rs_data[0], 32'h0);
    chk("t2_busy_vec0", {31'b0, busy_vec[0]}, 32'h0);
    // 3: two ports to the same register, port 1 wins
    we = 2'b11; wr_addr[0] = 5'd7; wr_addr[1] = 5'd7;
    wr_data[0] = 32'h11; wr_data[1] = 32'h22;
    rs_addr[1] = 5'd7;
    #1;
    chk("t3_bypass", rs_data[1], 32'h22);
    step();
    idle();
    chk("t3_stored", rs_data[1], 32'h22);
    // 4: scoreboard
    alloc_valid = 1'b1; alloc_rd = 5'd3;
    #1;
    chk("t4_first_stall", {31'b0, alloc_stall}, 32'h0);
    step();
    idle();
    rs_addr[0] = 5'd3;
    #1;
    chk("t4_rs_busy", {31'b0, rs_busy[0]}, 32'h1);
    alloc_valid = 1'b1; alloc_rd = 5'd3;
    #1;
    chk("t4_waw_stall", {31'b0, alloc_stall}, 32'h1);
    step();
    idle();
    chk("t4_busy_vec", busy_vec, 32'h0000_0008);
    we[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 32'h55;
    #1;
    chk("t4_wb_rs_busy", {31'b0, rs_busy[0]}, 32'h0);
    chk("t4_wb_bypass", rs_data[0], 32'h55);
    step();
    idle();
    chk("t4_busy_cleared", busy_vec, 32'h0);
    chk("t4_x3_stored", rs_data[0], 32'h55);
    // 5: writeback and alloc of the same register
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    step();
    idle();
    chk("t5_busy9", busy_vec, 32'h0000_0200);
    we[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 32'h99;
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    #1;
    chk("t5_no_stall", {31'b0, alloc_stall}, 32'h0);
    step();
    idle();
    rs_addr[1] = 5'd9;
    #1;
    chk("t5_busy9_kept", busy_vec, 32'h0000_0200);
    chk("t5_x9_data", rs_data[1], 32'h99);
    // 6: flush
    for (int r = 1; r <= 4; r++) begin
      if (r != 3) begin
        alloc_valid = 1'b1; alloc_rd = 5'(r);
        step();
      end
    end
    idle();
    chk("t6_pre_flush", busy_vec, 32'h0000_0216);
    flush = 1'b1;
    alloc_valid = 1'b1; alloc_rd = 5'd6;
    we[0] = 1'b1; wr_addr[0] = 5'd10; wr_data[0] = 32'hAB;
    step();
    idle();
    rs_addr[0] = 5'd10;
    rs_addr[1] = 5'd6;
    #1;
    chk("t6_flushed", busy_vec, 32'h0);
    chk("t6_x6_busy", {31'b0, rs_busy[1]}, 32'h0);
    chk("t6_x10_written", rs_data[0], 32'hAB);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
